// File: rtl/rvga_types.sv
// Shared types and constants for the cache miss sequencer.
//   ctrl_state_t     : sequencer state encoding
//   LINE_OFFSET_BITS : byte-offset bits within one cache line (32-byte lines)
package rvga_types;

   typedef enum logic [1:0] {
      IDLE,
      LOOKUP,
      WRITEBACK,
      FILL
   } ctrl_state_t;

   localparam int unsigned LINE_OFFSET_BITS = 5;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset, clears count
//   inc   : count one event this cycle
//   count : current value
module sat_counter #(
   parameter int unsigned width = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [width-1:0] count
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + width'(1);
      end
   end

endmodule

// File: rtl/cache_miss_ctrl.sv
// Sequencer for one set-associative cache: lookup, hit response, victim
// choice from the nmru select, dirty writeback and line fill.
//   clk, rst                  : clock (rising) / async active-low reset
//   mem_read, mem_write       : CPU request, held until mem_resp
//   mem_address               : CPU byte address
//   mem_resp                  : one-cycle CPU completion
//   hit_vector, dirty_vector  : per-way hit / dirty for the indexed line
//   victim_address            : line address of the selected victim
//   cache_replacement_select  : nmru one-hot victim
//   cache_replacement_update  : nmru write strobe
//   way_sel, load_line,
//   load_tag, set_dirty       : datapath way select and load strobes
//   pmem_read, pmem_write,
//   pmem_address, pmem_resp   : physical memory line transfer handshake
//   hit_count, miss_count,
//   wb_count                  : saturating performance counters
//   multi_hit_err             : sticky, more than one way hit in LOOKUP
module cache_miss_ctrl
   import rvga_types::*;
#(
   parameter int unsigned num_sets      = 4,
   parameter int unsigned lines_per_set = 16,
   parameter int unsigned addr_width    = 32,
   parameter int unsigned cnt_width     = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [addr_width-1:0] mem_address,
   output logic                  mem_resp,
   input  logic [num_sets-1:0]   hit_vector,
   input  logic [num_sets-1:0]   dirty_vector,
   input  logic [addr_width-1:0] victim_address,
   input  logic [num_sets-1:0]   cache_replacement_select,
   output logic                  cache_replacement_update,
   output logic [num_sets-1:0]   way_sel,
   output logic                  load_line,
   output logic                  load_tag,
   output logic                  set_dirty,
   output logic                  pmem_read,
   output logic                  pmem_write,
   output logic [addr_width-1:0] pmem_address,
   input  logic                  pmem_resp,
   output logic [cnt_width-1:0]  hit_count,
   output logic [cnt_width-1:0]  miss_count,
   output logic [cnt_width-1:0]  wb_count,
   output logic                  multi_hit_err
);

   localparam int unsigned INDEX_BITS = $clog2(lines_per_set);
   localparam int unsigned TAG_LSB    = LINE_OFFSET_BITS + INDEX_BITS;

   ctrl_state_t state, next_state;
   logic [num_sets-1:0] victim;
   logic                refill;
   logic                hit_inc, miss_inc, wb_inc;

   logic                  any_hit;
   logic                  multi_hit;
   logic [num_sets-1:0]   select_way;
   logic [addr_width-1:0] req_line, victim_line;

   assign any_hit    = |hit_vector;
   // More than one bit set: clearing the lowest set bit leaves something.
   assign multi_hit  = (hit_vector & (hit_vector - num_sets'(1))) != '0;
   // An empty nmru select falls back to way 0.
   assign select_way = (cache_replacement_select == '0) ? num_sets'(1)
                                                        : cache_replacement_select;

   // Line address = tag and index fields, byte offset cleared.
   assign req_line    = {mem_address[addr_width-1:TAG_LSB],
                         mem_address[TAG_LSB-1:LINE_OFFSET_BITS],
                         {LINE_OFFSET_BITS{1'b0}}};
   assign victim_line = {victim_address[addr_width-1:TAG_LSB],
                         victim_address[TAG_LSB-1:LINE_OFFSET_BITS],
                         {LINE_OFFSET_BITS{1'b0}}};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         victim        <= '0;
         refill        <= 1'b0;
         multi_hit_err <= 1'b0;
      end else begin
         state <= next_state;
         if (state == LOOKUP) begin
            if (multi_hit) multi_hit_err <= 1'b1;
            if (any_hit) refill <= 1'b0;
            else         victim <= select_way;
         end
         // The lookup after a fill is the completion of the same miss,
         // so its hit must not be counted.
         if ((state == FILL) && pmem_resp) refill <= 1'b1;
      end
   end

   always_comb begin
      next_state               = state;
      mem_resp                 = 1'b0;
      cache_replacement_update = 1'b0;
      way_sel                  = '0;
      load_line                = 1'b0;
      load_tag                 = 1'b0;
      set_dirty                = 1'b0;
      pmem_read                = 1'b0;
      pmem_write               = 1'b0;
      pmem_address             = '0;
      hit_inc                  = 1'b0;
      miss_inc                 = 1'b0;
      wb_inc                   = 1'b0;
      unique case (state)
         IDLE: begin
            if (mem_read || mem_write) next_state = LOOKUP;
         end
         LOOKUP: begin
            if (any_hit) begin
               mem_resp                 = 1'b1;
               way_sel                  = hit_vector;
               cache_replacement_update = 1'b1;
               set_dirty                = mem_write;
               hit_inc                  = !refill;
               next_state               = IDLE;
            end else begin
               miss_inc   = 1'b1;
               next_state = |(dirty_vector & select_way) ? WRITEBACK : FILL;
            end
         end
         WRITEBACK: begin
            pmem_write   = 1'b1;
            pmem_address = victim_line;
            if (pmem_resp) begin
               wb_inc     = 1'b1;
               next_state = FILL;
            end
         end
         FILL: begin
            pmem_read    = 1'b1;
            pmem_address = req_line;
            if (pmem_resp) begin
               way_sel    = victim;
               load_line  = 1'b1;
               load_tag   = 1'b1;
               next_state = LOOKUP;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   sat_counter #(.width(cnt_width)) u_hit_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (hit_inc),
      .count (hit_count)
   );

   sat_counter #(.width(cnt_width)) u_miss_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (miss_inc),
      .count (miss_count)
   );

   sat_counter #(.width(cnt_width)) u_wb_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (wb_inc),
      .count (wb_count)
   );

endmodule

// File: tb/tb_cache_miss_ctrl.sv
module tb_cache_miss_ctrl;

   localparam logic [31:0] ADDR  = 32'h0000_4568;
   localparam logic [31:0] ALINE = 32'h0000_4560;
   localparam logic [31:0] VADDR = 32'h0000_1234;
   localparam logic [31:0] VLINE = 32'h0000_1220;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_read = 1'b0, mem_write = 1'b0;
   logic [31:0] mem_address = ADDR;
   logic [3:0]  hit_vector = '0, dirty_vector = '0, repl_sel = '0;
   logic [31:0] victim_address = VADDR;
   logic        pmem_resp = 1'b0;

   logic        mem_resp, repl_upd, load_line, load_tag, set_dirty;
   logic        pmem_read, pmem_write, multi_hit_err;
   logic [3:0]  way_sel;
   logic [31:0] pmem_address;
   logic [15:0] hit_count, miss_count, wb_count;

   logic        s_mem_resp, s_repl_upd, s_load_line, s_load_tag, s_set_dirty;
   logic        s_pmem_read, s_pmem_write, s_multi_hit_err;
   logic [3:0]  s_way_sel;
   logic [31:0] s_pmem_address;
   logic [3:0]  s_hit_count, s_miss_count, s_wb_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cache_miss_ctrl dut (
      .clk(clk), .rst(rst),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_resp(mem_resp),
      .hit_vector(hit_vector), .dirty_vector(dirty_vector),
      .victim_address(victim_address),
      .cache_replacement_select(repl_sel), .cache_replacement_update(repl_upd),
      .way_sel(way_sel), .load_line(load_line), .load_tag(load_tag),
      .set_dirty(set_dirty),
      .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_address(pmem_address), .pmem_resp(pmem_resp),
      .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count),
      .multi_hit_err(multi_hit_err)
   );

   // Narrow-counter instance sharing all inputs, so saturation is reachable quickly.
   cache_miss_ctrl #(.cnt_width(4)) u_sat (
      .clk(clk), .rst(rst),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_resp(s_mem_resp),
      .hit_vector(hit_vector), .dirty_vector(dirty_vector),
      .victim_address(victim_address),
      .cache_replacement_select(repl_sel), .cache_replacement_update(s_repl_upd),
      .way_sel(s_way_sel), .load_line(s_load_line), .load_tag(s_load_tag),
      .set_dirty(s_set_dirty),
      .pmem_read(s_pmem_read), .pmem_write(s_pmem_write),
      .pmem_address(s_pmem_address), .pmem_resp(pmem_resp),
      .hit_count(s_hit_count), .miss_count(s_miss_count), .wb_count(s_wb_count),
      .multi_hit_err(s_multi_hit_err)
   );

   typedef struct {
      logic        rd, wr;
      logic [3:0]  hit, dirty, sel;
      logic        presp;
      logic [10:0] ctrl;   // {resp, way[3:0], upd, ll, lt, sd, pr, pw}
      logic [31:0] paddr;
      int          h, m, w;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rd, input logic wr, input logic [3:0] hit,
                      input logic [3:0] dirty, input logic [3:0] sel, input logic presp,
                      input logic resp, input logic [3:0] way, input logic upd,
                      input logic ll, input logic lt, input logic sd,
                      input logic pr, input logic pw, input logic [31:0] paddr,
                      input int h, input int m, input int w);
      vec_t v;
      v.rd = rd; v.wr = wr; v.hit = hit; v.dirty = dirty; v.sel = sel; v.presp = presp;
      v.ctrl = {resp, way, upd, ll, lt, sd, pr, pw};
      v.paddr = paddr; v.h = h; v.m = m; v.w = w;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic rd, input logic wr, input logic [3:0] hit,
                         input logic [3:0] dirty, input logic [3:0] sel, input logic presp);
      mem_read = rd; mem_write = wr; hit_vector = hit;
      dirty_vector = dirty; repl_sel = sel; pmem_resp = presp;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [10:0] ctrl_now();
      return {mem_resp, way_sel, repl_upd, load_line, load_tag, set_dirty,
              pmem_read, pmem_write};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //   rd wr hit   dirty sel  pr | rs way  up ll lt sd pr pw paddr  h m w
      add(1, 0, 4'h0, 4'h0, 4'h0, 0,  0, 4'h0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0); // read hit
      add(1, 0, 4'h2, 4'h0, 4'h0, 0,  1, 4'h2, 1, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
      add(0, 0, 4'h0, 4'h0, 4'h0, 0,  0, 4'h0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0);
      add(1, 0, 4'h0, 4'h0, 4'h4, 0,  0, 4'h0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0); // clean read miss
      add(1, 0, 4'h0, 4'h0, 4'h4, 0,  0, 4'h0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 0);
      add(1, 0, 4'h0, 4'h0, 4'h4, 0,  0, 4'h0, 0, 0, 0, 0, 1, 0, ALINE, 1, 1, 0);
      add(1, 0, 4'h0, 4'h0, 4'h4, 1,  0, 4'h4, 0, 1, 1, 0, 1, 0, ALINE, 1, 1, 0);
      add(1, 0, 4'h4, 4'h0, 4'h4, 0,  1, 4'h4, 1, 0, 0, 0, 0, 0, 32'h0, 1, 1, 0);
      add(0, 0, 4'h0, 4'h0, 4'h0, 0,  0, 4'h0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 1, 0);
      add(0, 1, 4'h0, 4'h1, 4'h1, 0,  0, 4'h0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 1, 0); // dirty write miss
      add(0, 1, 4'h0, 4'h1, 4'h1, 0,  0, 4'h0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 1, 0);
      add(0, 1, 4'h0, 4'h1, 4'h1, 0,  0, 4'h0, 0, 0, 0, 0, 0, 1, VLINE, 1, 2, 0);
      add(0, 1, 4'h0, 4'h1, 4'h1, 1,  0, 4'h0, 0, 0, 0, 0, 0, 1, VLINE, 1, 2, 0);
      add(0, 1, 4'h0, 4'h1, 4'h1, 0,  0, 4'h0, 0, 0, 0, 0, 1, 0, ALINE, 1, 2, 1);
      add(0, 1, 4'h0, 4'h1, 4'h1, 1,  0, 4'h1, 0, 1, 1, 0, 1, 0, ALINE, 1, 2, 1);
      add(0, 1, 4'h1, 4'h1, 4'h1, 0,  1, 4'h1, 1, 0, 0, 1, 0, 0, 32'h0, 1, 2, 1);
      add(0, 0, 4'h0, 4'h0, 4'h0, 0,  0, 4'h0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 2, 1);
      add(1, 0, 4'h0, 4'h0, 4'h0, 1,  0, 4'h0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 2, 1); // idle pmem_resp; empty select
      add(1, 0, 4'h0, 4'h0, 4'h0, 0,  0, 4'h0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 2, 1);
      add(1, 0, 4'h0, 4'h0, 4'h0, 1,  0, 4'h1, 0, 1, 1, 0, 1, 0, ALINE, 1, 3, 1);
      add(1, 0, 4'h1, 4'h0, 4'h0, 0,  1, 4'h1, 1, 0, 0, 0, 0, 0, 32'h0, 1, 3, 1);
      add(1, 1, 4'h0, 4'h0, 4'h0, 0,  0, 4'h0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 3, 1); // read+write hit
      add(1, 1, 4'h8, 4'h0, 4'h0, 0,  1, 4'h8, 1, 0, 0, 1, 0, 0, 32'h0, 1, 3, 1);
      add(0, 0, 4'h0, 4'h0, 4'h0, 0,  0, 4'h0, 0, 0, 0, 0, 0, 0, 32'h0, 2, 3, 1);
      add(1, 0, 4'h0, 4'h2, 4'h4, 0,  0, 4'h0, 0, 0, 0, 0, 0, 0, 32'h0, 2, 3, 1); // dirty non-victim
      add(1, 0, 4'h0, 4'h2, 4'h4, 0,  0, 4'h0, 0, 0, 0, 0, 0, 0, 32'h0, 2, 3, 1);
      add(1, 0, 4'h0, 4'h2, 4'h4, 1,  0, 4'h4, 0, 1, 1, 0, 1, 0, ALINE, 2, 4, 1);
      add(1, 0, 4'h4, 4'h2, 4'h4, 0,  1, 4'h4, 1, 0, 0, 0, 0, 0, 32'h0, 2, 4, 1);
      add(0, 0, 4'h0, 4'h0, 4'h0, 0,  0, 4'h0, 0, 0, 0, 0, 0, 0, 32'h0, 2, 4, 1);

      // Reset state
      #3;
      check("reset ctrl", 64'(ctrl_now()), 64'h0);
      check("reset pmem_address", 64'(pmem_address), 64'h0);
      #9;
      rst = 1'b1;

      foreach (vecs[i]) begin
         set_in(vecs[i].rd, vecs[i].wr, vecs[i].hit, vecs[i].dirty, vecs[i].sel, vecs[i].presp);
         check($sformatf("row%0d ctrl", i), 64'(ctrl_now()), 64'(vecs[i].ctrl));
         check($sformatf("row%0d pmem_address", i), 64'(pmem_address), 64'(vecs[i].paddr));
         check($sformatf("row%0d hit_count", i), 64'(hit_count), 64'(vecs[i].h));
         check($sformatf("row%0d miss_count", i), 64'(miss_count), 64'(vecs[i].m));
         check($sformatf("row%0d wb_count", i), 64'(wb_count), 64'(vecs[i].w));
         check($sformatf("row%0d multi_hit_err", i), 64'(multi_hit_err), 64'h0);
         tick();
      end

      // Reset asserted while a fill is outstanding
      set_in(1, 0, 4'h0, 4'h0, 4'h4, 0); tick();
      set_in(1, 0, 4'h0, 4'h0, 4'h4, 0); tick();
      set_in(1, 0, 4'h0, 4'h0, 4'h4, 0);
      check("fill pmem_read before reset", 64'(pmem_read), 64'h1);
      rst = 1'b0;
      #1;
      check("async reset pmem_read", 64'(pmem_read), 64'h0);
      check("async reset ctrl", 64'(ctrl_now()), 64'h0);
      check("async reset hit_count", 64'(hit_count), 64'h0);
      check("async reset miss_count", 64'(miss_count), 64'h0);
      check("async reset wb_count", 64'(wb_count), 64'h0);
      tick();
      rst = 1'b1;
      set_in(0, 0, 4'h0, 4'h0, 4'h0, 0);
      check("after reset idle ctrl", 64'(ctrl_now()), 64'h0);
      tick();
      set_in(1, 0, 4'h0, 4'h0, 4'h0, 0); tick();
      set_in(1, 0, 4'h2, 4'h0, 4'h0, 0);
      check("after reset lookup ctrl", 64'(ctrl_now()), 64'({1'b1, 4'h2, 6'b100000}));
      tick();
      set_in(0, 0, 4'h0, 4'h0, 4'h0, 0);
      check("after reset hit_count", 64'(hit_count), 64'h1);

      // Saturation: 19 misses, each completed by a refill hit
      rst = 1'b0;
      tick();
      rst = 1'b1;
      for (int n = 0; n < 19; n++) begin
         set_in(1, 0, 4'h0, 4'h0, 4'h4, 0); tick();
         set_in(1, 0, 4'h0, 4'h0, 4'h4, 0); tick();
         set_in(1, 0, 4'h0, 4'h0, 4'h4, 1); tick();
         set_in(1, 0, 4'h4, 4'h0, 4'h4, 0); tick();
      end
      set_in(0, 0, 4'h0, 4'h0, 4'h0, 0);
      check("sat miss_count narrow", 64'(s_miss_count), 64'hF);
      check("sat miss_count wide", 64'(miss_count), 64'd19);
      check("sat hit_count narrow", 64'(s_hit_count), 64'h0);
      check("sat hit_count wide", 64'(hit_count), 64'h0);

      // Multi-hit detection, sticky
      set_in(1, 0, 4'h0, 4'h0, 4'h0, 0); tick();
      set_in(1, 0, 4'h3, 4'h0, 4'h0, 0);
      check("multi_hit_err before edge", 64'(multi_hit_err), 64'h0);
      tick();
      set_in(0, 0, 4'h0, 4'h0, 4'h0, 0);
      check("multi_hit_err set", 64'(multi_hit_err), 64'h1);
      tick();
      set_in(1, 0, 4'h0, 4'h0, 4'h0, 0); tick();
      set_in(1, 0, 4'h1, 4'h0, 4'h0, 0); tick();
      set_in(0, 0, 4'h0, 4'h0, 4'h0, 0);
      check("multi_hit_err sticky", 64'(multi_hit_err), 64'h1);
      check("multi_hit_err sticky narrow", 64'(s_multi_hit_err), 64'h1);
      check("hit_count after single hit", 64'(hit_count), 64'h2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
